// File: rtl/wm8731_config_sequencer.sv
// WM8731 codec register-init sequencer: powers up, streams the init table to an
// I2C write controller, then services deferred headphone-volume writes.
module wm8731_config_sequencer #(
    parameter int unsigned STARTUP_CYCLES = 24000000,
    parameter int unsigned GAP_CYCLES     = 2400,
    parameter int unsigned TIMEOUT_CYCLES = 2400000,
    parameter logic [6:0]  DEV_ADDR       = 7'h1A
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [6:0]      vol,
    input  logic            vol_update,
    output logic [6:0]      addr,
    output logic [1:0][7:0] wdata,
    output logic            req,
    input  logic            ack,
    output logic            busy,
    output logic            done,
    output logic            error
);

    localparam int unsigned PWR_W = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [PWR_W-1:0] PWR_LAST = PWR_W'(STARTUP_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]       IDX_LAST = 3'd7;
    localparam logic [2:0]       IDX_VOL  = 3'd6;
    localparam logic [6:0]       VOL_RST  = 7'h79;

    typedef enum logic [2:0] {
        WAIT_PWR = 3'd0,
        LOAD     = 3'd1,
        REQ      = 3'd2,
        GAP      = 3'd3,
        DONE     = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [PWR_W-1:0] pwr_cnt_q, pwr_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             req_q, req_d;
    logic [6:0]       addr_q, addr_d;
    logic [15:0]      wdata_q, wdata_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic             pending_q, pending_d;
    logic [6:0]       vol_reg_q, vol_reg_d;
    logic             vol_wr_q, vol_wr_d;

    // Returns {reg[6:0], data[8:0]}, which splits directly into the two I2C bytes.
    function automatic logic [15:0] table_word(input logic [2:0] i, input logic [6:0] v);
        logic [6:0] r;
        logic [8:0] d;
        case (i)
            3'd0:    begin r = 7'd15; d = 9'h000;      end
            3'd1:    begin r = 7'd6;  d = 9'h067;      end
            3'd2:    begin r = 7'd4;  d = 9'h012;      end
            3'd3:    begin r = 7'd5;  d = 9'h000;      end
            3'd4:    begin r = 7'd7;  d = 9'h002;      end
            3'd5:    begin r = 7'd8;  d = 9'h019;      end
            3'd6:    begin r = 7'd2;  d = {2'b11, v};  end
            default: begin r = 7'd9;  d = 9'h001;      end
        endcase
        return {r, d};
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= WAIT_PWR;
            idx_q     <= 3'd0;
            pwr_cnt_q <= '0;
            gap_cnt_q <= '0;
            to_cnt_q  <= '0;
            req_q     <= 1'b0;
            addr_q    <= DEV_ADDR;
            wdata_q   <= 16'h0000;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            pending_q <= 1'b0;
            vol_reg_q <= VOL_RST;
            vol_wr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pwr_cnt_q <= pwr_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            to_cnt_q  <= to_cnt_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
            pending_q <= pending_d;
            vol_reg_q <= vol_reg_d;
            vol_wr_q  <= vol_wr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pwr_cnt_d = pwr_cnt_q;
        gap_cnt_d = gap_cnt_q;
        to_cnt_d  = to_cnt_q;
        req_d     = req_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        error_d   = error_q;
        pending_d = pending_q;
        vol_wr_d  = vol_wr_q;
        vol_reg_d = vol_update ? vol : vol_reg_q;

        case (state_q)
            WAIT_PWR: begin
                if (pwr_cnt_q == PWR_LAST) begin
                    idx_d   = 3'd0;
                    state_d = LOAD;
                end else if (pwr_cnt_q != '1) begin
                    pwr_cnt_d = pwr_cnt_q + 1'b1;
                end
            end
            LOAD: begin
                addr_d   = DEV_ADDR;
                wdata_d  = table_word(idx_q, vol_reg_q);
                req_d    = 1'b1;
                to_cnt_d = '0;
                state_d  = REQ;
            end
            REQ: begin
                // A missing ack is treated as a completed write so the table still finishes.
                if (req_q && ack) begin
                    req_d     = 1'b0;
                    gap_cnt_d = '0;
                    state_d   = GAP;
                end else if (to_cnt_q == TO_LAST) begin
                    error_d   = 1'b1;
                    req_d     = 1'b0;
                    gap_cnt_d = '0;
                    state_d   = GAP;
                end else if (to_cnt_q != '1) begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    if (vol_wr_q) begin
                        vol_wr_d = 1'b0;
                        state_d  = DONE;
                    end else if (idx_q == IDX_LAST) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = LOAD;
                    end
                end else if (gap_cnt_q != '1) begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (start) begin
                    error_d   = 1'b0;
                    pending_d = 1'b0;
                    vol_wr_d  = 1'b0;
                    idx_d     = 3'd0;
                    state_d   = LOAD;
                end else if (pending_q) begin
                    pending_d = 1'b0;
                    vol_wr_d  = 1'b1;
                    idx_d     = IDX_VOL;
                    state_d   = LOAD;
                end
            end
            default: begin
                state_d = WAIT_PWR;
            end
        endcase

        if (vol_update) begin
            pending_d = 1'b1;
        end

        busy_d = (state_d != DONE);
        done_d = (state_d == DONE);
    end

    assign addr  = addr_q;
    assign wdata = wdata_q;
    assign req   = req_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign error = error_q;

endmodule

// File: tb/tb_wm8731_config_sequencer.sv
// Directed bench for wm8731_config_sequencer with a transaction-level write model.
module tb_wm8731_config_sequencer;

    localparam int unsigned STARTUP = 10;
    localparam int unsigned GAP     = 4;
    localparam int unsigned TO      = 20;
    localparam int          ACK_HI  = 3;

    logic            clk = 1'b0;
    logic            reset, start, vol_update, ack, resp_ack, stray_ack;
    logic [6:0]      vol, addr;
    logic [1:0][7:0] wdata;
    logic            req, busy, done, error;

    wm8731_config_sequencer #(
        .STARTUP_CYCLES(STARTUP),
        .GAP_CYCLES    (GAP),
        .TIMEOUT_CYCLES(TO),
        .DEV_ADDR      (7'h1A)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .vol       (vol),
        .vol_update(vol_update),
        .addr      (addr),
        .wdata     (wdata),
        .req       (req),
        .ack       (ack),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;
    assign ack = resp_ack | stray_ack;

    typedef struct {
        logic [15:0] word;
        int          hi;
    } wr_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          n_writes = 0;
    wr_t         exp_q[$];
    logic [15:0] log_q[$];

    int reg_tab[8] = '{15, 6, 4, 5, 7, 8, 2, 9};
    int dat_tab[8] = '{'h000, 'h067, 'h012, 'h000, 'h002, 'h019, 'h180, 'h001};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    // I2C write word: 7-bit register number followed by 9-bit data.
    function automatic logic [15:0] model_word(input int r, input int d);
        return 16'((r << 9) | d);
    endfunction

    task automatic push_init(input logic [6:0] v, input int suppress_entry);
        wr_t w;
        for (int i = 0; i < 8; i++) begin
            w.word = model_word(reg_tab[i], dat_tab[i] | ((i == 6) ? int'(v) : 0));
            w.hi   = (i == suppress_entry) ? int'(TO) : ACK_HI;
            exp_q.push_back(w);
        end
    endtask

    task automatic push_vol(input logic [6:0] v);
        wr_t w;
        w.word = model_word(2, 'h180 | int'(v));
        w.hi   = ACK_HI;
        exp_q.push_back(w);
    endtask

    // Ack responder: pulse ack once, a few cycles after each rising req.
    int   resp_count   = 0;
    int   suppress_num = -1;
    logic ack_en       = 1'b1;
    logic req_prev     = 1'b0;
    initial begin
        resp_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && req === 1'b1 && !req_prev) begin
                req_prev = 1'b1;
                resp_count++;
                if (ack_en && resp_count != suppress_num) begin
                    repeat (ACK_HI - 1) @(negedge clk);
                    resp_ack = 1'b1;
                    @(negedge clk);
                    resp_ack = 1'b0;
                end
            end else if (req !== 1'b1) begin
                req_prev = 1'b0;
            end
        end
    end

    // Compare process: every write against the model, hold stability and status flags.
    int          hi_cnt = 0;
    wr_t         cur;
    logic [15:0] cur_word;
    initial begin
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                hi_cnt = 0;
            end else begin
                check("busy_xor_done", 32'(busy ^ done), 1);
                if (req === 1'b1) begin
                    if (hi_cnt == 0) begin
                        n_writes++;
                        cur_word = wdata;
                        log_q.push_back(wdata);
                        if (exp_q.size() == 0) begin
                            n_tests++;
                            n_fail++;
                            $display("FAIL unexpected_write: got %h, expected no write", wdata);
                            cur.hi = -1;
                        end else begin
                            cur = exp_q.pop_front();
                            check("write_word", wdata, cur.word);
                        end
                        check("write_addr", addr, 7'h1A);
                    end else begin
                        check("req_hold_wdata", wdata, cur_word);
                    end
                    check("busy_in_write", busy, 1);
                    hi_cnt++;
                end else if (hi_cnt > 0) begin
                    if (cur.hi >= 0) check("req_high_cycles", hi_cnt, cur.hi);
                    hi_cnt = 0;
                end
            end
        end
    end

    task automatic wait_first_req(input int t0, input int lim, output int lat);
        bit seen = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (req === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check("first_req_seen", seen, 1);
        lat = cyc - t0;
    endtask

    task automatic wait_idle(input int lim);
        bit ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (done === 1'b1 && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check("idle_reached", ok, 1);
        repeat (20) @(negedge clk);
        check("done_idle", done, 1);
        check("busy_idle", busy, 0);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int t0, lat, base;
        bit saw_busy;
        reset = 1'b0; start = 1'b0; vol_update = 1'b0; vol = 7'h00; stray_ack = 1'b0;

        #12;
        check("rst_req", req, 0);
        check("rst_addr", addr, 7'h1A);
        check("rst_wdata", wdata, 16'h0000);
        check("rst_busy", busy, 1);
        check("rst_done", done, 0);
        check("rst_error", error, 0);

        // Power-up init with the reset volume.
        push_init(7'h79, -1);
        @(negedge clk);
        reset = 1'b1;
        t0 = cyc;
        wait_first_req(t0, 100, lat);
        check("pwr_wait_min", 32'(lat >= int'(STARTUP)), 1);
        check("pwr_wait_max", 32'(lat <= int'(STARTUP) + 2), 1);
        wait_idle(400);
        check("init_writes", n_writes, 8);
        check("init_first_word", log_q[0], 16'h1E00);
        check("init_r8_word", log_q[5], 16'h1019);
        check("init_r2_word", log_q[6], 16'h05F9);
        check("init_error", error, 0);

        // Stray ack with no request pending.
        @(negedge clk); stray_ack = 1'b1;
        @(negedge clk); stray_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("stray_ack_req", req, 0);
        check("stray_ack_done", done, 1);

        // Volume update while idle.
        push_vol(7'h60);
        @(negedge clk); vol = 7'h60; vol_update = 1'b1;
        @(negedge clk); vol_update = 1'b0;
        saw_busy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (busy === 1'b1) saw_busy = 1'b1;
            @(negedge clk);
        end
        check("vol_busy", saw_busy, 1);
        wait_idle(200);
        check("vol_writes", n_writes, 9);
        check("vol_word", log_q[8], 16'h05E0);

        // Volume update during entry 2 is used by entry 6, then written once more.
        base = n_writes;
        push_init(7'h50, -1);
        push_vol(7'h50);
        pulse_start();
        t0 = cyc - 1;
        wait_first_req(t0, 50, lat);
        check("restart_no_pwr_wait", 32'(lat <= 3), 1);
        for (int i = 0; i < 200 && n_writes < base + 3; i++) @(negedge clk);
        check("reached_entry2", n_writes, base + 3);
        vol = 7'h50; vol_update = 1'b1;
        @(negedge clk); vol_update = 1'b0;
        wait_idle(600);
        check("defer_writes", n_writes - base, 9);
        check("defer_entry6", log_q[base + 6], 16'h05D0);
        check("defer_extra", log_q[base + 8], 16'h05D0);

        // Entry 3 never acked: timeout, sticky error, table continues.
        base = n_writes;
        suppress_num = resp_count + 4;
        push_init(7'h50, 3);
        pulse_start();
        wait_idle(800);
        check("timeout_writes", n_writes - base, 8);
        check("timeout_error", error, 1);

        // Start after error clears it; start while busy is ignored.
        base = n_writes;
        push_init(7'h50, -1);
        pulse_start();
        t0 = cyc - 1;
        wait_first_req(t0, 50, lat);
        check("err_cleared", error, 0);
        check("err_restart_no_pwr", 32'(lat <= 3), 1);
        for (int i = 0; i < 200 && n_writes < base + 2; i++) @(negedge clk);
        pulse_start();
        wait_idle(600);
        check("busy_start_writes", n_writes - base, 8);
        check("busy_start_error", error, 0);

        // Reset mid-transfer drops req asynchronously, then power-up again.
        base = n_writes;
        ack_en = 1'b0;
        begin
            wr_t w;
            w.word = model_word(15, 0);
            w.hi   = -1;
            exp_q.push_back(w);
        end
        pulse_start();
        wait_first_req(cyc, 50, lat);
        #2 reset = 1'b0;
        #1;
        check("async_req_drop", req, 0);
        check("async_busy", busy, 1);
        check("async_done", done, 0);
        check("async_wdata", wdata, 16'h0000);
        @(negedge clk);
        ack_en = 1'b1;
        push_init(7'h79, -1);
        @(negedge clk);
        reset = 1'b1;
        t0 = cyc;
        wait_first_req(t0, 100, lat);
        check("rerun_pwr_wait", 32'(lat >= int'(STARTUP)), 1);
        wait_idle(400);
        check("rerun_writes", n_writes - base, 9);
        check("rerun_r2_word", log_q[base + 7], 16'h05F9);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/wm8731_config_sequencer.md
WM8731_CONFIG_SEQUENCER -- requirements
Module: wm8731_config_sequencer

Interface
REQ-001 SHALL have parameter STARTUP_CYCLES, default 24000000, power-up wait before first write (100 ms at 240 MHz).
REQ-002 SHALL have parameter GAP_CYCLES, default 2400, idle cycles between consecutive writes.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 2400000, maximum cycles req may wait for ack.
REQ-004 SHALL have parameter DEV_ADDR, default 7'h1A, I2C device address.
REQ-005 SHALL have port clk  input  1  240 MHz clock; the only clock.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port start  input  1  one-cycle pulse that re-runs the full init sequence.
REQ-008 SHALL have port vol  input  7  headphone volume code.
REQ-009 SHALL have port vol_update  input  1  one-cycle pulse requesting a write of vol.
REQ-010 SHALL have port addr  output  7  I2C device address to the I2C controller.
REQ-011 SHALL have port wdata  output  2x8  write bytes; wdata[1] is sent first and equals {reg[6:0], data[8]}; wdata[0] equals data[7:0].
REQ-012 SHALL have port req  output  1  transfer request to the I2C controller.
REQ-013 SHALL have port ack  input  1  transfer-complete acknowledge from the I2C controller.
REQ-014 SHALL have ports busy, done, error  output  1 each  status flags.

Function
REQ-015 SHALL implement states WAIT_PWR, LOAD, REQ, GAP, DONE.
REQ-016 WAIT_PWR: count STARTUP_CYCLES, then go to LOAD with index 0.
REQ-017 Init table, 9-bit data, SHALL be issued in order: 0 R15=0x000; 1 R6=0x067; 2 R4=0x012; 3 R5=0x000; 4 R7=0x002; 5 R8=0x019; 6 R2=0x180|vol_reg; 7 R9=0x001.
REQ-018 LOAD: drive addr=DEV_ADDR and wdata from the table entry; assert req in the same cycle; go to REQ.
REQ-019 req, addr and wdata SHALL be held stable while in REQ.
REQ-020 A transfer completes on the first clk edge where req=1 and ack=1; req SHALL be 0 in the next cycle.
REQ-021 ack while req=0 SHALL be ignored.
REQ-022 On completion, SHALL go to GAP and count GAP_CYCLES, then advance.
REQ-023 After index 7 completes and its gap expires, SHALL enter DONE; otherwise SHALL increment index and go to LOAD.
REQ-024 If ack does not arrive within TIMEOUT_CYCLES in REQ, SHALL set error (sticky), drop req, and proceed to GAP as if completed.
REQ-025 vol_reg (7 bit) SHALL load vol on every vol_update pulse, in any state.
REQ-026 A vol_update pulse SHALL set a pending flag.
REQ-027 In DONE with pending set: clear pending, write R2=0x180|vol_reg via LOAD/REQ/GAP, then return to DONE.
REQ-028 vol_update during init SHALL be deferred until DONE; entry 6 SHALL already use the latest vol_reg.
REQ-029 start in DONE SHALL clear error and restart at LOAD with index 0, skipping WAIT_PWR.
REQ-030 start outside DONE SHALL be ignored.
REQ-031 start and pending together in DONE: start wins; pending SHALL be cleared.
REQ-032 busy SHALL be 1 in every state except DONE; done SHALL equal (state==DONE and not writing).
REQ-033 Counters SHALL be sized by $clog2 of their parameter and SHALL saturate, never wrap.

Reset
REQ-034 On reset low: state=WAIT_PWR, index=0, counters=0, req=0, addr=DEV_ADDR, wdata=0, busy=1, done=0, error=0, pending=0, vol_reg=7'h79.
REQ-035 Reset mid-transfer SHALL drop req immediately (asynchronously), and the sequence SHALL restart from WAIT_PWR.

Verification
REQ-036 Bench SHALL cover: STARTUP_CYCLES=10, GAP_CYCLES=4, ack pulsed 3 cycles after each req -> 8 writes in order, first wdata={8'h1E,8'h00}, R8 write wdata={8'h10,8'h19}; done=1 after the last gap.
REQ-037 Bench SHALL cover: vol=7'h60 with vol_update in DONE -> one write wdata={8'h05,8'hE0}, busy high during the write, done returns to 1.
REQ-038 Bench SHALL cover: vol_update (vol=7'h50) during entry 2 -> entry 6 sends {8'h05,8'hD0}, then exactly one extra R2 write after the init.
REQ-039 Bench SHALL cover: ack never asserted for entry 3 with TIMEOUT_CYCLES=20 -> req drops after 20 cycles, error=1, entries 4-7 still issued.
REQ-040 Bench SHALL cover: start in DONE after an error -> error=0, 8 writes with no power wait; start while busy -> no effect.
REQ-041 Bench SHALL cover: reset asserted while req=1 -> req=0 without waiting for a clk edge; after release, the sequence restarts from WAIT_PWR.
